// File: rtl/qpsk_tx_sequencer.sv
// Transmit sequencer for the I/Q polyphase RRC filter pair: clock-enable divider,
// per-symbol PRBS9 data for both branches, and a run/drain burst controller.
module qpsk_tx_sequencer #(
   parameter int unsigned UPSAMPLE    = 4,
   parameter int unsigned NCOEF       = 24,
   parameter int unsigned DIV_NBITS   = 8,
   parameter int unsigned BURST_NBITS = 16,
   parameter logic [8:0]  SEED_I      = 9'h1FF,
   parameter logic [8:0]  SEED_Q      = 9'h0A5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   stop,
   input  logic [DIV_NBITS-1:0]   div_ratio,
   input  logic [BURST_NBITS-1:0] burst_len,
   output logic                   tx_enable,
   output logic                   tx_in_i,
   output logic                   tx_in_q,
   output logic                   symbol_strobe,
   output logic                   busy,
   output logic                   done,
   output logic [BURST_NBITS-1:0] sym_count
);

   localparam int unsigned PH_W = $clog2(UPSAMPLE);
   localparam int unsigned DR_W = $clog2(NCOEF + 1);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(UPSAMPLE - 1);
   localparam logic [DR_W-1:0] DR_LAST = DR_W'(NCOEF - 1);
   // An all-zero seed would lock the LFSR, so it is swapped for all-ones.
   localparam logic [8:0] SEED_I_EFF = (SEED_I == 9'd0) ? 9'h1FF : SEED_I;
   localparam logic [8:0] SEED_Q_EFF = (SEED_Q == 9'd0) ? 9'h1FF : SEED_Q;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   state_t                 state, state_n;
   logic [DIV_NBITS-1:0]   div_ratio_r, div_ratio_n;
   logic [BURST_NBITS-1:0] burst_len_r, burst_len_n;
   logic [DIV_NBITS-1:0]   div_cnt, div_cnt_n;
   logic [PH_W-1:0]        phase, phase_n;
   logic [DR_W-1:0]        drain_cnt, drain_cnt_n;
   logic [8:0]             lfsr_i, lfsr_i_n;
   logic [8:0]             lfsr_q, lfsr_q_n;
   logic [BURST_NBITS-1:0] sym_count_n;
   logic [BURST_NBITS-1:0] sym_inc;
   logic                   stop_pend, stop_pend_n;
   logic                   burst_hit, burst_hit_n;
   logic                   tx_enable_n;
   logic                   done_n;
   logic                   sym_last;

   function automatic logic [8:0] prbs9_step(input logic [8:0] s);
      return {s[7:0], s[8] ^ s[4]};
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         div_ratio_r <= '0;
         burst_len_r <= '0;
         div_cnt     <= '0;
         phase       <= '0;
         drain_cnt   <= '0;
         lfsr_i      <= SEED_I_EFF;
         lfsr_q      <= SEED_Q_EFF;
         sym_count   <= '0;
         stop_pend   <= 1'b0;
         burst_hit   <= 1'b0;
         tx_enable   <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_n;
         div_ratio_r <= div_ratio_n;
         burst_len_r <= burst_len_n;
         div_cnt     <= div_cnt_n;
         phase       <= phase_n;
         drain_cnt   <= drain_cnt_n;
         lfsr_i      <= lfsr_i_n;
         lfsr_q      <= lfsr_q_n;
         sym_count   <= sym_count_n;
         stop_pend   <= stop_pend_n;
         burst_hit   <= burst_hit_n;
         tx_enable   <= tx_enable_n;
         done        <= done_n;
      end
   end

   assign sym_last = tx_enable & (phase == PH_LAST);
   assign sym_inc  = sym_count + BURST_NBITS'(1);

   always_comb begin
      state_n     = state;
      div_ratio_n = div_ratio_r;
      burst_len_n = burst_len_r;
      div_cnt_n   = div_cnt;
      phase_n     = phase;
      drain_cnt_n = drain_cnt;
      lfsr_i_n    = lfsr_i;
      lfsr_q_n    = lfsr_q;
      sym_count_n = sym_count;
      stop_pend_n = stop_pend;
      burst_hit_n = burst_hit;
      done_n      = 1'b0;

      unique case (state)
         IDLE: begin
            if (start) begin
               state_n     = RUN;
               div_ratio_n = div_ratio;
               burst_len_n = burst_len;
               div_cnt_n   = '0;
               phase_n     = '0;
               drain_cnt_n = '0;
               lfsr_i_n    = SEED_I_EFF;
               lfsr_q_n    = SEED_Q_EFF;
               sym_count_n = '0;
               stop_pend_n = stop;
               burst_hit_n = 1'b0;
            end
         end

         RUN: begin
            div_cnt_n = (div_cnt == div_ratio_r) ? '0 : div_cnt + DIV_NBITS'(1);
            if (stop)
               stop_pend_n = 1'b1;
            if (symbol_strobe) begin
               sym_count_n = sym_inc;
               if ((burst_len_r != '0) && (sym_inc == burst_len_r))
                  burst_hit_n = 1'b1;
            end
            if (tx_enable)
               phase_n = phase + PH_W'(1);
            // Exit only on the last enable of a symbol so no partial symbol goes out.
            if (sym_last) begin
               lfsr_i_n = prbs9_step(lfsr_i);
               lfsr_q_n = prbs9_step(lfsr_q);
               if (stop_pend | burst_hit) begin
                  state_n     = DRAIN;
                  drain_cnt_n = '0;
               end
            end
         end

         DRAIN: begin
            div_cnt_n = (div_cnt == div_ratio_r) ? '0 : div_cnt + DIV_NBITS'(1);
            if (tx_enable) begin
               if (drain_cnt == DR_LAST) begin
                  state_n     = IDLE;
                  done_n      = 1'b1;
                  stop_pend_n = 1'b0;
                  burst_hit_n = 1'b0;
               end else begin
                  drain_cnt_n = drain_cnt + DR_W'(1);
               end
            end
         end

         default: state_n = IDLE;
      endcase

      // Registered enable: decoded from the divider value the next cycle will hold.
      tx_enable_n = (state_n != IDLE) && (div_cnt_n == div_ratio_n);
   end

   assign busy          = (state != IDLE);
   assign symbol_strobe = tx_enable & (state == RUN) & (phase == '0);
   assign tx_in_i       = (state == RUN) & lfsr_i[8];
   assign tx_in_q       = (state == RUN) & lfsr_q[8];

endmodule

// File: tb/tb_qpsk_tx_sequencer.sv
// Directed bench for qpsk_tx_sequencer: cycle-exact expectations for continuous,
// divided, burst, stop, ignored-request and reset scenarios.
module tb_qpsk_tx_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [7:0]  div_ratio = '0;
   logic [15:0] burst_len = '0;
   logic        tx_enable, tx_in_i, tx_in_q, symbol_strobe, busy, done;
   logic [15:0] sym_count;

   int errors = 0;
   int checks = 0;

   // First 16 PRBS9 output bits (bit k = symbol k+1), worked out by hand from the seeds.
   logic [15:0] i_bits = 16'hC1FF;
   logic [15:0] q_bits = 16'h3D4A;

   qpsk_tx_sequencer #(
      .UPSAMPLE(4),
      .NCOEF(24),
      .DIV_NBITS(8),
      .BURST_NBITS(16),
      .SEED_I(9'h1FF),
      .SEED_Q(9'h0A5)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .stop(stop),
      .div_ratio(div_ratio),
      .burst_len(burst_len),
      .tx_enable(tx_enable),
      .tx_in_i(tx_in_i),
      .tx_in_q(tx_in_q),
      .symbol_strobe(symbol_strobe),
      .busy(busy),
      .done(done),
      .sym_count(sym_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic go(input logic [7:0] dr, input logic [15:0] bl, input logic with_stop);
      div_ratio = dr;
      burst_len = bl;
      start     = 1'b1;
      stop      = with_stop;
      step();
      start     = 1'b0;
      stop      = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values and stop in IDLE
      step();
      check("rst tx_enable", tx_enable, 0);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst strobe", symbol_strobe, 0);
      check("rst tx_in_i", tx_in_i, 0);
      check("rst tx_in_q", tx_in_q, 0);
      check("rst sym_count", sym_count, 0);
      reset = 1'b0;
      repeat (3) step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      step();
      check("idle stop busy", busy, 0);
      check("idle stop en", tx_enable, 0);

      // Continuous run, start ignored in RUN, stop at start of symbol 17
      go(8'd0, 16'd0, 1'b0);
      for (int k = 0; k < 96; k++) begin
         check($sformatf("cont en k=%0d", k), tx_enable, k < 92);
         check($sformatf("cont strobe k=%0d", k), symbol_strobe, (k < 68) && (k % 4 == 0));
         check($sformatf("cont busy k=%0d", k), busy, k < 92);
         check($sformatf("cont done k=%0d", k), done, k == 92);
         if (k < 64) begin
            check($sformatf("cont i k=%0d", k), tx_in_i, i_bits[k / 4]);
            check($sformatf("cont q k=%0d", k), tx_in_q, q_bits[k / 4]);
         end else if (k >= 68) begin
            check($sformatf("cont drain i k=%0d", k), tx_in_i, 0);
            check($sformatf("cont drain q k=%0d", k), tx_in_q, 0);
         end
         if (k == 63)
            check("cont sym_count", sym_count, 16);
         start     = (k == 30);
         div_ratio = (k == 30) ? 8'd5 : 8'd0;
         burst_len = (k == 30) ? 16'd1 : 16'd0;
         stop      = (k == 64);
         step();
      end
      start = 1'b0;
      stop  = 1'b0;
      check("cont final sym_count", sym_count, 17);

      // Divider 3, stop during symbol 5, start+stop during DRAIN
      go(8'd2, 16'd0, 1'b0);
      for (int j = 0; j < 141; j++) begin
         check($sformatf("div en j=%0d", j), tx_enable, (j < 132) && (j % 3 == 2));
         check($sformatf("div strobe j=%0d", j), symbol_strobe, (j < 60) && (j % 12 == 2));
         check($sformatf("div i j=%0d", j), tx_in_i, (j < 60) ? i_bits[j / 12] : 1'b0);
         check($sformatf("div busy j=%0d", j), busy, j < 132);
         check($sformatf("div done j=%0d", j), done, j == 132);
         stop      = (j == 48) || (j == 80);
         start     = (j == 80);
         div_ratio = (j == 80) ? 8'd0 : 8'd2;
         step();
      end
      start = 1'b0;
      stop  = 1'b0;
      check("div sym_count", sym_count, 5);

      // Burst of 3 symbols
      go(8'd0, 16'd3, 1'b0);
      for (int j = 0; j < 41; j++) begin
         check($sformatf("burst en j=%0d", j), tx_enable, j < 36);
         check($sformatf("burst strobe j=%0d", j), symbol_strobe, (j < 12) && (j % 4 == 0));
         check($sformatf("burst i j=%0d", j), tx_in_i, (j < 12) ? i_bits[j / 4] : 1'b0);
         check($sformatf("burst q j=%0d", j), tx_in_q, (j < 12) ? q_bits[j / 4] : 1'b0);
         check($sformatf("burst busy j=%0d", j), busy, j < 36);
         check($sformatf("burst done j=%0d", j), done, j == 36);
         step();
      end
      check("burst sym_count", sym_count, 3);

      // Stop at phase 1 of symbol 5
      go(8'd0, 16'd0, 1'b0);
      for (int j = 0; j < 47; j++) begin
         check($sformatf("mid en j=%0d", j), tx_enable, j < 44);
         check($sformatf("mid strobe j=%0d", j), symbol_strobe, (j < 20) && (j % 4 == 0));
         check($sformatf("mid i j=%0d", j), tx_in_i, (j < 20) ? i_bits[j / 4] : 1'b0);
         check($sformatf("mid q j=%0d", j), tx_in_q, (j < 20) ? q_bits[j / 4] : 1'b0);
         check($sformatf("mid done j=%0d", j), done, j == 44);
         stop = (j == 17);
         step();
      end
      stop = 1'b0;

      // Simultaneous start and stop: one symbol only
      go(8'd0, 16'd0, 1'b1);
      for (int j = 0; j < 31; j++) begin
         check($sformatf("ss en j=%0d", j), tx_enable, j < 28);
         check($sformatf("ss strobe j=%0d", j), symbol_strobe, j == 0);
         check($sformatf("ss i j=%0d", j), tx_in_i, (j < 4) ? i_bits[0] : 1'b0);
         check($sformatf("ss done j=%0d", j), done, j == 28);
         step();
      end
      check("ss sym_count", sym_count, 1);

      // Reset mid-DRAIN, then restart reproduces the sequence
      go(8'd0, 16'd0, 1'b1);
      repeat (10) step();
      check("pre-rst busy", busy, 1);
      reset = 1'b1;
      #1;
      check("arst en", tx_enable, 0);
      check("arst busy", busy, 0);
      check("arst done", done, 0);
      check("arst strobe", symbol_strobe, 0);
      check("arst sym_count", sym_count, 0);
      step();
      step();
      reset = 1'b0;
      for (int j = 0; j < 30; j++) begin
         check($sformatf("post-rst done j=%0d", j), done, 0);
         check($sformatf("post-rst busy j=%0d", j), busy, 0);
         step();
      end
      go(8'd0, 16'd0, 1'b0);
      for (int j = 0; j < 40; j++) begin
         check($sformatf("restart i j=%0d", j), tx_in_i, i_bits[j / 4]);
         check($sformatf("restart q j=%0d", j), tx_in_q, q_bits[j / 4]);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/qpsk_tx_sequencer.md
Name: qpsk_tx_sequencer

Overview:
- Controller for the I/Q pair of polyphase RRC transmit filters in the QPSK chain.
- Generates the shared filter clock-enable (tx_enable) from a programmable divider.
- Produces per-symbol I and Q data bits from two independent PRBS9 generators, each bit held for UPSAMPLE enables.
- Runs a start / stop / burst / drain state machine so each transmission ends with the filter delay line flushed.

Parameters:
- UPSAMPLE, 4: enables per symbol; power of 2, ≥2.
- NCOEF, 24: filter tap count; sets drain length.
- DIV_NBITS, 8: width of div_ratio.
- BURST_NBITS, 16: width of burst_len and sym_count.
- SEED_I, 9'h1FF: PRBS9 seed for the I branch.
- SEED_Q, 9'h0A5: PRBS9 seed for the Q branch.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high.
- start, in, 1: single-cycle start request.
- stop, in, 1: single-cycle stop request.
- div_ratio, in, DIV_NBITS: tx_enable period minus 1; sampled on accepted start.
- burst_len, in, BURST_NBITS: symbols to send; 0 = continuous; sampled on accepted start.
- tx_enable, out, 1: filter clock-enable.
- tx_in_i, out, 1: I data bit to the I filter.
- tx_in_q, out, 1: Q data bit to the Q filter.
- symbol_strobe, out, 1: high with the tx_enable that carries phase 0 of a new symbol.
- busy, out, 1: high in RUN or DRAIN.
- done, out, 1: one-cycle pulse on the DRAIN→IDLE transition.
- sym_count, out, BURST_NBITS: symbols launched since the last start; wraps at its width.

Behaviour:
- Reset values: all outputs 0; state = IDLE; div counter, phase counter and drain counter = 0; LFSR_I = SEED_I, LFSR_Q = SEED_Q. A seed of 0 is replaced by 9'h1FF.
- Divider (RUN/DRAIN only): div_cnt counts 0..div_ratio_r, then wraps to 0. tx_enable is registered and high for one cycle when div_cnt == div_ratio_r. With div_ratio = 0, tx_enable is high every cycle.
- Phase: phase counts 0..UPSAMPLE-1, advancing on each tx_enable. symbol_strobe = tx_enable & (phase == 0).
- PRBS9, polynomial x^9+x^5+1:
  - Output bit = lfsr[8].
  - Update: lfsr <= {lfsr[7:0], lfsr[8]^lfsr[4]}.
  - Advances once per symbol, on the tx_enable where phase == UPSAMPLE-1.
  - tx_in_i / tx_in_q are stable for all UPSAMPLE enables of a symbol.
- IDLE:
  - tx_enable, tx_in_i, tx_in_q = 0.
  - On start: latch div_ratio and burst_len, reload both LFSRs from seeds, clear counters and sym_count, go to RUN next cycle.
  - stop in IDLE is ignored.
- RUN:
  - First tx_enable occurs div_ratio+1 cycles after entry, with phase 0. For div_ratio = 0 that is the first RUN cycle.
  - sym_count increments on each symbol_strobe.
  - A stop pulse sets stop_pend.
  - Burst completion: when burst_len_r ≠ 0, the stop condition is the symbol_strobe at which sym_count reaches burst_len_r.
  - Transition: on the tx_enable with phase == UPSAMPLE-1 and (stop_pend | burst done), go to DRAIN. No partial symbols are ever sent.
  - start in RUN is ignored.
- DRAIN:
  - tx_enable continues at the same rate; tx_in_i = tx_in_q = 0.
  - Drain counter counts exactly NCOEF enables.
  - After the NCOEF-th enable: go to IDLE, pulse done, clear stop_pend. busy falls in the same cycle done rises.
  - start and stop in DRAIN are ignored.
- Simultaneous start & stop in IDLE: start wins, and stop_pend is set. The burst then ends after the first complete symbol.
- Asynchronous reset mid-operation: immediate return to reset values, no done pulse.
- sym_count wraps silently. A burst_len comparison compares the wrapped value.

Test Plan:
- Continuous run:
  - Stimulus: reset, then div_ratio=0, burst_len=0, start at cycle 10.
  - Response: busy=1 from cycle 11; tx_enable=1 every cycle; symbol_strobe at cycles 11, 15, 19…; tx_in_i = 1 for the first 9 symbols and 0 for symbols 10–14.
- Divider:
  - Stimulus: div_ratio=2, burst_len=0, start.
  - Response: tx_enable every 3rd cycle; symbol_strobe every 12 cycles; tx_in_i never changes between symbol_strobes.
- Burst:
  - Stimulus: div_ratio=0, burst_len=3, start.
  - Response: exactly 12 enables in RUN, then 24 drain enables with tx_in_i = tx_in_q = 0; done pulses once; sym_count = 3; busy low afterwards.
- Mid-symbol stop:
  - Stimulus: continuous run, stop asserted at phase 1 of symbol 5.
  - Response: symbol 5 completes all 4 enables, then DRAIN for 24 enables, then done.
- Ignored requests:
  - Stimulus: start during RUN; start and stop during DRAIN; stop in IDLE.
  - Response: no state change, no LFSR reload, done timing unchanged.
- Reset mid-DRAIN:
  - Stimulus: assert reset mid-DRAIN.
  - Response: all outputs 0 immediately, no done pulse; a following start reproduces the identical first-symbol bit sequence.
